// File: rtl/alu_issue_stage.sv
// ID/EX boundary: ALU-control decode, ID/EX pipeline register with stall/flush, EX/MEM and MEM/WB operand forwarding.
// Latency: ID->EX 1 cycle; forwarding onto operandA/operandB/ex_storeData is combinational.
// Backpressure: stall holds every stored field, flush inserts a bubble; ALU_ISSUE_IMM_EN enables aluOp=11 opcode decode.
module alu_issue_stage #(
    parameter int DATA_W = 32,  // ALU is fixed at 32 bits; other widths are not supported
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [1:0]        id_aluOp,
    input  logic [5:0]        id_funct,
    input  logic [5:0]        id_opcode,
    input  logic              id_aluSrc,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [DATA_W-1:0] id_readData1,
    input  logic [DATA_W-1:0] id_readData2,
    input  logic [15:0]       id_imm16,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_regWrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regWrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [3:0]        ex_aluControl,
    output logic [DATA_W-1:0] operandA,
    output logic [DATA_W-1:0] operandB,
    output logic [DATA_W-1:0] ex_storeData,
    output logic              ex_illegal
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef struct packed {
        logic              vld;
        logic [3:0]        ctrl;
        logic              illegal;
        logic              alu_src;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } idex_t;

    idex_t             idex_q;
    idex_t             idex_d;
    logic [3:0]        dec_ctrl;
    logic              dec_illegal;
    logic              dec_zext;
    logic [DATA_W-1:0] imm32;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        dec_zext    = 1'b0;
        case (id_aluOp)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b100111: dec_ctrl = CTRL_NOR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: begin
`ifdef ALU_ISSUE_IMM_EN
                case (id_opcode)
                    6'b001000: dec_ctrl = CTRL_ADD;
                    6'b001010: dec_ctrl = CTRL_SLT;
                    6'b001100: begin dec_ctrl = CTRL_AND; dec_zext = 1'b1; end
                    6'b001101: begin dec_ctrl = CTRL_OR;  dec_zext = 1'b1; end
                    default:   dec_illegal = 1'b1;
                endcase
`else
                dec_illegal = 1'b1;
`endif
            end
        endcase
    end

`ifndef ALU_ISSUE_IMM_EN
    // Opcode only matters to the immediate decoder.
    logic unused_opcode;
    assign unused_opcode = ^id_opcode;
`endif

    assign imm32 = dec_zext ? {{(DATA_W-16){1'b0}}, id_imm16}
                            : {{(DATA_W-16){id_imm16[15]}}, id_imm16};

    always_comb begin
        idex_d         = '0;
        idex_d.vld     = id_valid;
        idex_d.ctrl    = dec_ctrl;
        idex_d.illegal = dec_illegal & id_valid;
        idex_d.alu_src = id_aluSrc;
        idex_d.rs      = id_rs;
        idex_d.rt      = id_rt;
        idex_d.rd1     = id_readData1;
        idex_d.rd2     = id_readData2;
        idex_d.imm     = imm32;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            idex_q <= '0;
        else if (flush)
            idex_q <= '0;
        else if (!stall)
            idex_q <= idex_d;
    end

    // EX/MEM is the younger producer, so it takes precedence; r0 is hardwired zero and never forwarded.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] r,
                                              input logic [DATA_W-1:0] stored);
        if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == r))
            return exmem_result;
        else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == r))
            return memwb_result;
        else
            return stored;
    endfunction

    assign fwd_a = fwd(idex_q.rs, idex_q.rd1);
    assign fwd_b = fwd(idex_q.rt, idex_q.rd2);

    assign ex_valid      = idex_q.vld;
    assign ex_aluControl = idex_q.ctrl;
    assign ex_illegal    = idex_q.illegal;
    assign operandA      = fwd_a;
    assign operandB      = idex_q.alu_src ? idex_q.imm : fwd_b;
    assign ex_storeData  = fwd_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected EX outputs are queued when stimulus is applied and checked when observed.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [1:0]  id_aluOp;
    logic [5:0]  id_funct;
    logic [5:0]  id_opcode;
    logic        id_aluSrc;
    logic [4:0]  id_rs, id_rt;
    logic [31:0] id_readData1, id_readData2;
    logic [15:0] id_imm16;
    logic        stall, flush;
    logic        exmem_regWrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [3:0]  ex_aluControl;
    logic [31:0] operandA, operandB, ex_storeData;
    logic        ex_illegal;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        logic        vld;
        logic [3:0]  ctrl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
    } exp_t;

    exp_t sb[$];

    alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_aluOp(id_aluOp),
        .id_funct(id_funct), .id_opcode(id_opcode), .id_aluSrc(id_aluSrc),
        .id_rs(id_rs), .id_rt(id_rt), .id_readData1(id_readData1),
        .id_readData2(id_readData2), .id_imm16(id_imm16), .stall(stall), .flush(flush),
        .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_aluControl(ex_aluControl), .operandA(operandA),
        .operandB(operandB), .ex_storeData(ex_storeData), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic vld, input logic [3:0] ctrl, input logic ill,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
        exp_t e;
        e.tag = tag; e.vld = vld; e.ctrl = ctrl; e.ill = ill; e.a = a; e.b = b; e.st = st;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        tests++;
        assert (sb.size() != 0)
        else begin
            failed++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".valid"},   {31'd0, ex_valid},      {31'd0, e.vld});
        chk({e.tag, ".ctrl"},    {28'd0, ex_aluControl}, {28'd0, e.ctrl});
        chk({e.tag, ".illegal"}, {31'd0, ex_illegal},    {31'd0, e.ill});
        chk({e.tag, ".opA"},     operandA,               e.a);
        chk({e.tag, ".opB"},     operandB,               e.b);
        chk({e.tag, ".store"},   ex_storeData,           e.st);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                          input logic [5:0] opc, input logic src, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [15:0] imm);
        id_valid = v; id_aluOp = op; id_funct = fn; id_opcode = opc; id_aluSrc = src;
        id_rs = rs; id_rt = rt; id_readData1 = d1; id_readData2 = d2; id_imm16 = imm;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        exmem_regWrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
        memwb_regWrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;

        // Reset held two cycles with a valid instruction presented
        set_id(1'b1, 2'b10, 6'b100000, 6'd0, 1'b0, 5'd1, 5'd2, 32'h11, 32'h22, 16'h0);
        push("reset0", 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); pop_check();
        push("reset1", 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); pop_check();

        // R-type slt loads on the first edge after release
        rst_n = 1'b1;
        set_id(1'b1, 2'b10, 6'b101010, 6'd0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd9, 16'h0);
        push("slt", 1'b1, 4'b0111, 1'b0, 32'd5, 32'd9, 32'd9);
        tick(); pop_check();

        set_id(1'b1, 2'b10, 6'b100111, 6'd0, 1'b0, 5'd3, 5'd4, 32'hF0, 32'h0F, 16'h0);
        push("nor", 1'b1, 4'b1100, 1'b0, 32'hF0, 32'h0F, 32'h0F);
        tick(); pop_check();

        set_id(1'b1, 2'b10, 6'b000011, 6'd0, 1'b0, 5'd3, 5'd4, 32'd3, 32'd4, 16'h0);
        push("bad_funct", 1'b1, 4'b0010, 1'b1, 32'd3, 32'd4, 32'd4);
        tick(); pop_check();

        // A bubble never reports illegal
        set_id(1'b0, 2'b10, 6'b000011, 6'd0, 1'b0, 5'd3, 5'd4, 32'd3, 32'd4, 16'h0);
        push("bad_funct_bubble", 1'b0, 4'b0010, 1'b0, 32'd3, 32'd4, 32'd4);
        tick(); pop_check();

        // Forwarding on ex_rs = ex_rt = 8
        set_id(1'b1, 2'b00, 6'd0, 6'd0, 1'b0, 5'd8, 5'd8, 32'h1111, 32'h2222, 16'h0);
        push("lw_add", 1'b1, 4'b0010, 1'b0, 32'h1111, 32'h2222, 32'h2222);
        tick(); pop_check();

        stall = 1'b1;
        exmem_regWrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'hAAAA;
        memwb_regWrite = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h5555;
        #1;
        push("fwd_exmem", 1'b1, 4'b0010, 1'b0, 32'hAAAA, 32'hAAAA, 32'hAAAA);
        pop_check();
        exmem_regWrite = 1'b0;
        #1;
        push("fwd_memwb", 1'b1, 4'b0010, 1'b0, 32'h5555, 32'h5555, 32'h5555);
        pop_check();
        exmem_regWrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        push("fwd_r0", 1'b1, 4'b0010, 1'b0, 32'h1111, 32'h2222, 32'h2222);
        pop_check();
        exmem_rd = 5'd9; memwb_rd = 5'd8;
        #1;
        push("fwd_memwb_other_exmem", 1'b1, 4'b0010, 1'b0, 32'h5555, 32'h5555, 32'h5555);
        pop_check();
        exmem_regWrite = 1'b0; memwb_regWrite = 1'b0;

        // Stall three cycles while ID inputs change
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 2'b01, 6'd0, 6'd0, 1'b1, 5'(i + 10), 5'(i + 20),
                   32'(i + 100), 32'(i + 200), 16'hFFFF);
            push("stall_hold", 1'b1, 4'b0010, 1'b0, 32'h1111, 32'h2222, 32'h2222);
            tick(); pop_check();
        end

        // Flush beats a simultaneous stall
        flush = 1'b1;
        push("flush_over_stall", 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); pop_check();
        flush = 1'b0; stall = 1'b0;

        // Immediate op: ori with a negative-looking immediate
        set_id(1'b1, 2'b11, 6'd0, 6'b001101, 1'b1, 5'd5, 5'd6, 32'd7, 32'h33, 16'h8001);
`ifdef ALU_ISSUE_IMM_EN
        push("ori", 1'b1, 4'b0001, 1'b0, 32'd7, 32'h0000_8001, 32'h33);
`else
        push("ori", 1'b1, 4'b0010, 1'b1, 32'd7, 32'hFFFF_8001, 32'h33);
`endif
        tick(); pop_check();

        // beq subtract, then reset in the middle of a stall
        set_id(1'b1, 2'b01, 6'd0, 6'd0, 1'b0, 5'd7, 5'd0, 32'h40, 32'h41, 16'h0);
        push("beq_sub", 1'b1, 4'b0110, 1'b0, 32'h40, 32'h41, 32'h41);
        tick(); pop_check();
        stall = 1'b1; rst_n = 1'b0;
        push("reset_mid_stall", 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); pop_check();
        stall = 1'b0; rst_n = 1'b1;

        tests++;
        assert (sb.size() == 0)
        else begin
            failed++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
